rgbw_frame_decoder: RTL and testbench

RGBW_FRAME_DECODER -- requirements
Module: rgbw_frame_decoder

---
 rtl/rgbw_frame_decoder.sv | 131 +++++++++++++
 tb/tb_rgbw_frame_decoder.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rgbw_frame_decoder.sv
// rtl/rgbw_frame_decoder.sv - SPI byte-stream decoder committing checksummed RGBW colour and intensity frames
module rgbw_frame_decoder #(
    parameter logic [7:0] CMD_COLOR  = 8'h01,
    parameter logic [7:0] CMD_INTENS = 8'h02
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       cs,
    input  logic       rdy,
    input  logic [7:0] data,
    output logic [7:0] red,
    output logic [7:0] green,
    output logic [7:0] blue,
    output logic [7:0] white,
    output logic [7:0] intensity,
    output logic       update,
    output logic       frame_err
);

    typedef enum logic [1:0] {IDLE, PAYLOAD, CHECK, DRAIN} state_t;

    state_t      state, state_n;
    logic        rdy_q;
    logic [2:0]  idx, idx_n;
    logic [2:0]  need, need_n;
    logic [7:0]  chk, chk_n;
    logic [7:0]  shadow [4];
    logic        accept;
    logic        store;
    logic        commit;
    logic        err_n;

    // rdy is a level; only its rising edge carries a new byte
    assign accept = rdy & ~rdy_q;

    always_comb begin
        state_n = state;
        idx_n   = idx;
        need_n  = need;
        chk_n   = chk;
        store   = 1'b0;
        commit  = 1'b0;
        err_n   = 1'b0;
        if (cs) begin
            // a deselect mid-frame is an incomplete frame; any byte edge here is dropped
            state_n = IDLE;
            idx_n   = 3'd0;
            chk_n   = 8'h00;
            err_n   = (state == PAYLOAD) || (state == CHECK);
        end else if (accept) begin
            case (state)
                IDLE: begin
                    idx_n = 3'd0;
                    if (data == CMD_COLOR) begin
                        chk_n   = data;
                        need_n  = 3'd4;
                        state_n = PAYLOAD;
                    end else if (data == CMD_INTENS) begin
                        chk_n   = data;
                        need_n  = 3'd1;
                        state_n = PAYLOAD;
                    end else begin
                        err_n   = 1'b1;
                        state_n = DRAIN;
                    end
                end
                PAYLOAD: begin
                    store = 1'b1;
                    chk_n = chk ^ data;
                    idx_n = idx + 3'd1;
                    if ((idx + 3'd1) == need) begin
                        state_n = CHECK;
                    end
                end
                CHECK: begin
                    if (data == chk) begin
                        commit = 1'b1;
                    end else begin
                        err_n = 1'b1;
                    end
                    state_n = DRAIN;
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            rdy_q     <= 1'b0;
            idx       <= 3'd0;
            need      <= 3'd0;
            chk       <= 8'h00;
            for (int k = 0; k < 4; k++) begin
                shadow[k] <= 8'h00;
            end
            red       <= 8'h00;
            green     <= 8'h00;
            blue      <= 8'h00;
            white     <= 8'h00;
            intensity <= 8'hFF;
            update    <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            state     <= state_n;
            rdy_q     <= rdy;
            idx       <= idx_n;
            need      <= need_n;
            chk       <= chk_n;
            update    <= commit;
            frame_err <= err_n;
            if (store) begin
                shadow[idx[1:0]] <= data;
            end
            // need tells which register group this frame owns
            if (commit) begin
                if (need == 3'd4) begin
                    red   <= shadow[0];
                    green <= shadow[1];
                    blue  <= shadow[2];
                    white <= shadow[3];
                end else begin
                    intensity <= shadow[0];
                end
            end
        end
    end

endmodule

// File: tb/tb_rgbw_frame_decoder.sv
// tb/tb_rgbw_frame_decoder.sv - table, directed and randomized checks of rgbw_frame_decoder
module tb_rgbw_frame_decoder;

    logic       clk;
    logic       reset;
    logic       cs;
    logic       rdy;
    logic [7:0] data;
    logic [7:0] red, green, blue, white, intensity;
    logic       update, frame_err;

    rgbw_frame_decoder dut (
        .clk       (clk),
        .reset     (reset),
        .cs        (cs),
        .rdy       (rdy),
        .data      (data),
        .red       (red),
        .green     (green),
        .blue      (blue),
        .white     (white),
        .intensity (intensity),
        .update    (update),
        .frame_err (frame_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int passed = 0;
    int upd_cnt = 0;
    int err_cnt = 0;
    int both_cnt = 0;

    always @(negedge clk) begin
        if (update) upd_cnt++;
        if (frame_err) err_cnt++;
        if (update && frame_err) both_cnt++;
    end

    typedef struct {
        int          n;
        logic [63:0] b;
        logic [7:0]  r, g, bl, w, i;
        int          eu, ee;
    } vec_t;

    vec_t vt[10];
    logic [7:0] fb[$];
    logic [7:0] m_r, m_g, m_b, m_w, m_i;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input int hold);
        data = b;
        rdy  = 1'b1;
        repeat (hold) tick();
        rdy  = 1'b0;
        tick();
    endtask

    task automatic frame_begin();
        cs = 1'b0;
        tick();
    endtask

    task automatic frame_end();
        cs = 1'b1;
        tick();
        tick();
    endtask

    task automatic run_fb(input bit random_timing);
        frame_begin();
        foreach (fb[k]) begin
            send_byte(fb[k], random_timing ? int'($urandom_range(1, 3)) : 1);
            if (random_timing) repeat ($urandom_range(0, 2)) tick();
        end
        frame_end();
    endtask

    task automatic check_outs(input string tag, input logic [7:0] r, g, b, w, i);
        check({tag, ".red"}, red, r);
        check({tag, ".green"}, green, g);
        check({tag, ".blue"}, blue, b);
        check({tag, ".white"}, white, w);
        check({tag, ".intensity"}, intensity, i);
    endtask

    // frame-level reference: judge the whole byte list of one cs-low window
    task automatic model_frame(output int eu, output int ee);
        int need;
        logic [7:0] x;
        eu = 0;
        ee = 0;
        if (fb.size() == 0) return;
        if (fb[0] == 8'h01) need = 4;
        else if (fb[0] == 8'h02) need = 1;
        else begin ee = 1; return; end
        if (fb.size() < need + 2) begin ee = 1; return; end
        x = 8'h00;
        for (int k = 0; k <= need; k++) x ^= fb[k];
        if (fb[need + 1] != x) begin ee = 1; return; end
        eu = 1;
        if (need == 4) begin
            m_r = fb[1]; m_g = fb[2]; m_b = fb[3]; m_w = fb[4];
        end else begin
            m_i = fb[1];
        end
    endtask

    task automatic gen_frame();
        int kind;
        int need;
        logic [7:0] x;
        logic [7:0] c;
        kind = $urandom_range(0, 5);
        fb.delete();
        if (kind == 4) begin
            do c = 8'($urandom); while (c == 8'h01 || c == 8'h02);
            fb.push_back(c);
            repeat ($urandom_range(0, 3)) fb.push_back(8'($urandom));
            return;
        end
        c = ($urandom_range(0, 1) == 1) ? 8'h02 : 8'h01;
        need = (c == 8'h01) ? 4 : 1;
        fb.push_back(c);
        x = c;
        for (int k = 0; k < need; k++) begin
            fb.push_back(8'($urandom));
            x ^= fb[k + 1];
        end
        if (kind == 2) x ^= 8'($urandom_range(1, 255));
        fb.push_back(x);
        if (kind == 3) begin
            int keep;
            keep = $urandom_range(1, need + 1);
            while (fb.size() > keep) void'(fb.pop_back());
        end
        if (kind == 5) repeat ($urandom_range(1, 3)) fb.push_back(8'($urandom));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        int u0, e0, eu, ee;
        string tag;

        vt[0] = '{6, 64'h01_10_20_30_40_41_00_00, 8'h10, 8'h20, 8'h30, 8'h40, 8'hFF, 1, 0};
        vt[1] = '{3, 64'h02_80_82_00_00_00_00_00, 8'h10, 8'h20, 8'h30, 8'h40, 8'h80, 1, 0};
        vt[2] = '{8, 64'h01_10_20_30_40_00_01_41, 8'h10, 8'h20, 8'h30, 8'h40, 8'h80, 0, 1};
        vt[3] = '{2, 64'h01_10_00_00_00_00_00_00, 8'h10, 8'h20, 8'h30, 8'h40, 8'h80, 0, 1};
        vt[4] = '{3, 64'h02_55_57_00_00_00_00_00, 8'h10, 8'h20, 8'h30, 8'h40, 8'h55, 1, 0};
        vt[5] = '{1, 64'h7E_00_00_00_00_00_00_00, 8'h10, 8'h20, 8'h30, 8'h40, 8'h55, 0, 1};
        vt[6] = '{4, 64'h7E_02_66_64_00_00_00_00, 8'h10, 8'h20, 8'h30, 8'h40, 8'h55, 0, 1};
        vt[7] = '{1, 64'h01_00_00_00_00_00_00_00, 8'h10, 8'h20, 8'h30, 8'h40, 8'h55, 0, 1};
        vt[8] = '{5, 64'h01_11_22_33_44_00_00_00, 8'h10, 8'h20, 8'h30, 8'h40, 8'h55, 0, 1};
        vt[9] = '{0, 64'h00_00_00_00_00_00_00_00, 8'h10, 8'h20, 8'h30, 8'h40, 8'h55, 0, 0};

        reset = 1'b1;
        cs    = 1'b1;
        rdy   = 1'b0;
        data  = 8'h00;
        tick();
        tick();
        reset = 1'b0;
        tick();
        check_outs("reset", 8'h00, 8'h00, 8'h00, 8'h00, 8'hFF);
        check("reset.update", update, 1'b0);
        check("reset.frame_err", frame_err, 1'b0);

        for (int v = 0; v < 10; v++) begin
            tag = $sformatf("vec%0d", v);
            fb.delete();
            for (int k = 0; k < vt[v].n; k++) fb.push_back(vt[v].b[63 - 8*k -: 8]);
            u0 = upd_cnt;
            e0 = err_cnt;
            run_fb(1'b0);
            check_outs(tag, vt[v].r, vt[v].g, vt[v].bl, vt[v].w, vt[v].i);
            check({tag, ".updates"}, upd_cnt - u0, vt[v].eu);
            check({tag, ".errors"}, err_cnt - e0, vt[v].ee);
        end

        // commit latency: outputs and update change exactly one clk after the checksum edge
        frame_begin();
        send_byte(8'h01, 1);
        send_byte(8'h01, 1);
        send_byte(8'h02, 1);
        send_byte(8'h03, 1);
        send_byte(8'h04, 1);
        data = 8'h05;
        rdy  = 1'b1;
        check("lat.red_before", red, 8'h10);
        check("lat.update_before", update, 1'b0);
        tick();
        check_outs("lat", 8'h01, 8'h02, 8'h03, 8'h04, 8'h55);
        check("lat.update", update, 1'b1);
        rdy = 1'b0;
        tick();
        check("lat.update_after", update, 1'b0);
        frame_end();

        // a rdy level held for 3 clk is one byte
        u0 = upd_cnt;
        e0 = err_cnt;
        frame_begin();
        send_byte(8'h02, 3);
        send_byte(8'h77, 1);
        send_byte(8'h75, 1);
        frame_end();
        check("hold.intensity", intensity, 8'h77);
        check("hold.updates", upd_cnt - u0, 1);
        check("hold.errors", err_cnt - e0, 0);

        // cs high on the rdy edge drops the byte, in IDLE and mid-frame
        u0 = upd_cnt;
        e0 = err_cnt;
        data = 8'h02;
        rdy  = 1'b1;
        tick();
        rdy  = 1'b0;
        tick();
        frame_begin();
        send_byte(8'h02, 1);
        data = 8'h44;
        rdy  = 1'b1;
        cs   = 1'b1;
        tick();
        rdy  = 1'b0;
        tick();
        tick();
        check("prio.abort_errors", err_cnt - e0, 1);
        fb = '{8'h02, 8'h12, 8'h10};
        run_fb(1'b0);
        check("prio.intensity", intensity, 8'h12);
        check("prio.updates", upd_cnt - u0, 1);
        check("prio.errors", err_cnt - e0, 1);

        // reset mid-frame discards silently
        u0 = upd_cnt;
        e0 = err_cnt;
        frame_begin();
        send_byte(8'h01, 1);
        send_byte(8'hAA, 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        check_outs("rst_mid", 8'h00, 8'h00, 8'h00, 8'h00, 8'hFF);
        frame_end();
        check("rst_mid.updates", upd_cnt - u0, 0);
        check("rst_mid.errors", err_cnt - e0, 0);
        fb = '{8'h01, 8'h0A, 8'h0B, 8'h0C, 8'h0D, 8'h01};
        run_fb(1'b0);
        check_outs("rst_after", 8'h0A, 8'h0B, 8'h0C, 8'h0D, 8'hFF);

        m_r = 8'h0A; m_g = 8'h0B; m_b = 8'h0C; m_w = 8'h0D; m_i = 8'hFF;
        for (int f = 0; f < 60; f++) begin
            tag = $sformatf("rnd%0d", f);
            gen_frame();
            u0 = upd_cnt;
            e0 = err_cnt;
            run_fb(1'b1);
            model_frame(eu, ee);
            check_outs(tag, m_r, m_g, m_b, m_w, m_i);
            check({tag, ".updates"}, upd_cnt - u0, eu);
            check({tag, ".errors"}, err_cnt - e0, ee);
        end

        check("never_both_pulses", both_cnt, 0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
